ft_recovery_seq: RTL and testbench

Lockstep recovery sequencer for the dual zeroriscy pair.
- Compares the regfile write ports of core 0 and core 1 every cycle.
- Keeps a golden shadow register file and PC checkpoint built from agreeing writes.
- On divergence it halts both cores, restores all GPRs and the NPC through the debug ports with a per-core req/gnt handshake, then resumes.
- Falls back to a core reset if the cores fail to halt.

---
 rtl/ft_recovery_seq_if.sv | 27 ++
 rtl/ft_recovery_seq.sv | 185 ++++++++++++++++++
 tb/tb_ft_recovery_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_recovery_seq_if.sv
// rtl/ft_recovery_seq_if.sv - shared debug bus between the recovery sequencer and the core pair
interface ft_recovery_seq_if;
    logic [1:0]  halted;
    logic [1:0]  gnt;
    logic [1:0]  req;
    logic        we;
    logic [14:0] addr;
    logic [31:0] wdata;

    modport master (
        input  halted,
        input  gnt,
        output req,
        output we,
        output addr,
        output wdata
    );

    modport slave (
        output halted,
        output gnt,
        input  req,
        input  we,
        input  addr,
        input  wdata
    );
endinterface

// File: rtl/ft_recovery_seq.sv
// rtl/ft_recovery_seq.sv - lockstep recovery sequencer, optional shadow parity under FT_SHADOW_PARITY_EN
module ft_recovery_seq #(
    parameter int          TIMEOUT      = 64,
    parameter int          RST_CYCLES   = 4,
    parameter logic [14:0] DBG_GPR_BASE = 15'h400,
    parameter logic [14:0] DBG_NPC_ADDR = 15'h2000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_a_i,
    input  logic [4:0]        addr_a_i,
    input  logic [31:0]       data_a_i,
    input  logic              we_b_i,
    input  logic [4:0]        addr_b_i,
    input  logic [31:0]       data_b_i,
    input  logic [31:0]       pc_i,
    ft_recovery_seq_if.master dbg,
    output logic              halt_o,
    output logic              resume_o,
    output logic              reset_o,
    output logic              busy_o,
    output logic [7:0]        err_count_o
);
    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WAIT_HALT,
        S_WR_GPR,
        S_WR_NPC,
        S_RESUME,
        S_RESET_CORES
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [31:0]   shadow [32];
    logic [31:0]   pc_ckpt;
    logic [4:0]    idx;
    logic [TW-1:0] timer;
    logic [1:0]    flags;
    logic [7:0]    err_count;
    logic          mismatch;
    logic          par_err;
    logic          in_wr;
    logic [1:0]    hs_req;
    logic          beat_done;
    logic          halt_expired;
    logic          rst_done;
    logic          err_inc;

    assign mismatch = (we_a_i != we_b_i) |
                      (we_a_i & ((addr_a_i != addr_b_i) | (data_a_i != data_b_i)));

`ifdef FT_SHADOW_PARITY_EN
    logic shadow_par [32];
    assign par_err = (state == S_WR_GPR) && ((^shadow[idx]) != shadow_par[idx]);
`else
    assign par_err = 1'b0;
`endif

    // A core keeps requesting until it has been granted once for the current beat
    assign in_wr        = ((state == S_WR_GPR) && !par_err) || (state == S_WR_NPC);
    assign hs_req       = in_wr ? ~flags : 2'b00;
    assign beat_done    = in_wr && (&(flags | (dbg.gnt & hs_req)));
    assign halt_expired = (timer == TW'(TIMEOUT - 1));
    assign rst_done     = (timer == TW'(RST_CYCLES - 1));
    assign err_inc      = ((state == S_IDLE) && mismatch) || par_err;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_d;
    end

    // Next-state selection; a halt that arrives on the timeout cycle still wins
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:        if (mismatch) state_d = S_HALT;
            S_HALT:        state_d = S_WAIT_HALT;
            S_WAIT_HALT: begin
                if (dbg.halted == 2'b11) state_d = S_WR_GPR;
                else if (halt_expired)   state_d = S_RESET_CORES;
            end
            S_WR_GPR: begin
                if (par_err)                          state_d = S_RESET_CORES;
                else if (beat_done && idx == 5'd31)   state_d = S_WR_NPC;
            end
            S_WR_NPC:      if (beat_done) state_d = S_RESUME;
            S_RESUME:      state_d = S_IDLE;
            S_RESET_CORES: if (rst_done) state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; the debug bus is quiet outside the write states
    always_comb begin
        dbg.req   = hs_req;
        dbg.we    = 1'b0;
        dbg.addr  = 15'd0;
        dbg.wdata = 32'd0;
        halt_o    = (state == S_HALT);
        resume_o  = (state == S_RESUME);
        reset_o   = (state != S_RESET_CORES);
        busy_o    = (state != S_IDLE);
        if (in_wr) begin
            dbg.we = 1'b1;
            if (state == S_WR_GPR) begin
                dbg.addr  = DBG_GPR_BASE + {8'd0, idx, 2'b00};
                dbg.wdata = shadow[idx];
            end else begin
                dbg.addr  = DBG_NPC_ADDR;
                dbg.wdata = pc_ckpt;
            end
        end
    end

    assign err_count_o = err_count;

    // Shadow file, checkpoint, beat index, timer, grant flags and error counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= 32'd0;
`ifdef FT_SHADOW_PARITY_EN
                shadow_par[i] <= 1'b0;
`endif
            end
            pc_ckpt   <= 32'd0;
            idx       <= 5'd0;
            timer     <= '0;
            flags     <= 2'b00;
            err_count <= 8'd0;
        end else begin
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
            case (state)
                S_IDLE: begin
                    if (!mismatch) begin
                        pc_ckpt <= pc_i;
                        if (we_a_i && addr_a_i != 5'd0) begin
                            shadow[addr_a_i] <= data_a_i;
`ifdef FT_SHADOW_PARITY_EN
                            shadow_par[addr_a_i] <= ^data_a_i;
`endif
                        end
                    end
                end
                S_HALT: timer <= '0;
                S_WAIT_HALT: begin
                    if (dbg.halted == 2'b11) idx <= 5'd1;
                    else if (halt_expired)   timer <= '0;
                    else                     timer <= timer + 1'b1;
                end
                S_WR_GPR: begin
                    if (par_err) begin
                        timer <= '0;
                        flags <= 2'b00;
                    end else if (beat_done) begin
                        flags <= 2'b00;
                        idx   <= idx + 5'd1;
                    end else begin
                        flags <= flags | (dbg.gnt & hs_req);
                    end
                end
                S_WR_NPC: begin
                    if (beat_done) flags <= 2'b00;
                    else           flags <= flags | (dbg.gnt & hs_req);
                end
                S_RESET_CORES: begin
                    timer   <= timer + 1'b1;
                    pc_ckpt <= 32'd0;
                    for (int i = 0; i < 32; i++) begin
                        shadow[i] <= 32'd0;
`ifdef FT_SHADOW_PARITY_EN
                        shadow_par[i] <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ft_recovery_seq.sv
// tb/tb_ft_recovery_seq.sv - directed self-checking bench for ft_recovery_seq
module tb_ft_recovery_seq;
    logic        clk;
    logic        rst_ni;
    logic        we_a, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [31:0] pc;
    logic        halt_o, resume_o, reset_o, busy_o;
    logic [7:0]  err_count_o;
    logic [1:0]  halted;
    logic        auto_gnt;
    logic [1:0]  man_gnt;

    int checks = 0;
    int errors = 0;

    int          wcnt [2][33];
    logic [31:0] wdat [2][33];
    int          tot [2];
    int          other_wr;
    int          base_cnt [2][33];
    int          base_tot [2];

    ft_recovery_seq_if dif();

    assign dif.halted = halted;
    assign dif.gnt    = auto_gnt ? dif.req : man_gnt;

    ft_recovery_seq dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .we_a_i      (we_a),
        .addr_a_i    (addr_a),
        .data_a_i    (data_a),
        .we_b_i      (we_b),
        .addr_b_i    (addr_b),
        .data_b_i    (data_b),
        .pc_i        (pc),
        .dbg         (dif),
        .halt_o      (halt_o),
        .resume_o    (resume_o),
        .reset_o     (reset_o),
        .busy_o      (busy_o),
        .err_count_o (err_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core-side model: every granted write lands in that core's log
    always @(posedge clk) begin
        if (rst_ni) begin
            for (int k = 0; k < 2; k++) begin
                if (dif.req[k] && dif.gnt[k] && dif.we) begin
                    tot[k] <= tot[k] + 1;
                    if (dif.addr == 15'h2000) begin
                        wcnt[k][32] <= wcnt[k][32] + 1;
                        wdat[k][32] <= dif.wdata;
                    end else if (dif.addr >= 15'h400 && dif.addr < 15'h480 && dif.addr[1:0] == 2'b00) begin
                        wcnt[k][(dif.addr - 15'h400) >> 2] <= wcnt[k][(dif.addr - 15'h400) >> 2] + 1;
                        wdat[k][(dif.addr - 15'h400) >> 2] <= dif.wdata;
                    end else begin
                        other_wr <= other_wr + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            base_tot[k] = tot[k];
            for (int s = 0; s < 33; s++) base_cnt[k][s] = wcnt[k][s];
        end
    endtask

    function automatic int dcnt(input int k, input int s);
        return wcnt[k][s] - base_cnt[k][s];
    endfunction

    task automatic idle_in();
        we_a = 1'b0; we_b = 1'b0;
        addr_a = 5'd0; addr_b = 5'd0;
        data_a = 32'd0; data_b = 32'd0;
    endtask

    task automatic drive_mismatch();
        we_a = 1'b1; we_b = 1'b0;
        addr_a = 5'd3; addr_b = 5'd3;
        data_a = 32'hA5A5_0001; data_b = 32'hA5A5_0001;
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (busy_o && n < lim) begin
            step();
            n++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},    {30'd0, dif.req}, 32'd0);
        chk({tag, "_we"},     {31'd0, dif.we},  32'd0);
        chk({tag, "_addr"},   {17'd0, dif.addr}, 32'd0);
        chk({tag, "_wdata"},  dif.wdata, 32'd0);
        chk({tag, "_halt"},   {31'd0, halt_o}, 32'd0);
        chk({tag, "_resume"}, {31'd0, resume_o}, 32'd0);
        chk({tag, "_reset"},  {31'd0, reset_o}, 32'd1);
        chk({tag, "_busy"},   {31'd0, busy_o}, 32'd0);
        chk({tag, "_err"},    {24'd0, err_count_o}, 32'd0);
    endtask

    initial begin
        int n;
        int m;
        int tmo;
        for (int k = 0; k < 2; k++) begin
            tot[k] = 0;
            for (int s = 0; s < 33; s++) begin
                wcnt[k][s] = 0;
                wdat[k][s] = 32'd0;
            end
        end
        other_wr = 0;
        rst_ni = 1'b0;
        idle_in();
        pc = 32'd0;
        halted = 2'b11;
        auto_gnt = 1'b1;
        man_gnt = 2'b00;
        step(); step(); step();
        chk_reset_outputs("rst");
        rst_ni = 1'b1;
        step();

        // Agreeing writes then a data mismatch on x6
        we_a = 1'b1; we_b = 1'b1; addr_a = 5'd5; addr_b = 5'd5;
        data_a = 32'h1234_5678; data_b = 32'h1234_5678; pc = 32'h0FC;
        step();
        addr_a = 5'd0; addr_b = 5'd0; data_a = 32'hFFFF_FFFF; data_b = 32'hFFFF_FFFF; pc = 32'h100;
        step();
        snap();
        addr_a = 5'd6; addr_b = 5'd6; data_a = 32'h1; data_b = 32'h2; pc = 32'h104;
        step();
        chk("halt_pulse", {31'd0, halt_o}, 32'd1);
        chk("err_1", {24'd0, err_count_o}, 32'd1);
        chk("busy_halt", {31'd0, busy_o}, 32'd1);
        idle_in();
        pc = 32'h108;
        step();
        chk("halt_once", {31'd0, halt_o}, 32'd0);
        n = 1;
        while (!resume_o && n < 100) begin
            step();
            n++;
        end
        chk("latency", n, 34);
        chk("resume_hi", {31'd0, resume_o}, 32'd1);
        step();
        chk("resume_once", {31'd0, resume_o}, 32'd0);
        chk("busy_after", {31'd0, busy_o}, 32'd0);
        chk("gpr5_cnt0", dcnt(0, 5), 1);
        chk("gpr5_cnt1", dcnt(1, 5), 1);
        chk("gpr5_dat0", wdat[0][5], 32'h1234_5678);
        chk("gpr5_dat1", wdat[1][5], 32'h1234_5678);
        chk("gpr0_cnt0", dcnt(0, 0), 0);
        chk("gpr0_cnt1", dcnt(1, 0), 0);
        chk("gpr6_dat0", wdat[0][6], 32'd0);
        chk("npc_dat0", wdat[0][32], 32'h100);
        chk("npc_dat1", wdat[1][32], 32'h100);
        chk("tot0", tot[0] - base_tot[0], 32);
        chk("tot1", tot[1] - base_tot[1], 32);
        chk("other", other_wr, 0);

        // Skewed grants on the first GPR beat
        snap();
        drive_mismatch();
        step();
        chk("err_2", {24'd0, err_count_o}, 32'd2);
        idle_in();
        auto_gnt = 1'b0;
        man_gnt = 2'b00;
        step();
        step();
        chk("skew_req_a", {30'd0, dif.req}, 32'd3);
        chk("skew_addr_a", {17'd0, dif.addr}, 32'h404);
        chk("skew_we", {31'd0, dif.we}, 32'd1);
        man_gnt = 2'b01;
        step();
        chk("skew_req_b", {30'd0, dif.req}, 32'd2);
        man_gnt = 2'b00;
        step();
        chk("skew_req_c", {30'd0, dif.req}, 32'd2);
        chk("skew_addr_c", {17'd0, dif.addr}, 32'h404);
        man_gnt = 2'b10;
        step();
        chk("skew_req_d", {30'd0, dif.req}, 32'd3);
        chk("skew_addr_d", {17'd0, dif.addr}, 32'h408);
        man_gnt = 2'b00;
        auto_gnt = 1'b1;
        wait_idle(100, n);
        chk("skew_done", {31'd0, busy_o}, 32'd0);
        chk("skew_gpr1_c0", dcnt(0, 1), 1);
        chk("skew_gpr1_c1", dcnt(1, 1), 1);
        chk("skew_gpr5", wdat[1][5], 32'h1234_5678);

        // Halt never completes: forced core reset
        snap();
        halted = 2'b01;
        drive_mismatch();
        step();
        chk("err_3", {24'd0, err_count_o}, 32'd3);
        idle_in();
        n = 0;
        while (reset_o && n < 200) begin
            step();
            n++;
        end
        chk("tmo_cycles", n, 65);
        m = 0;
        while (!reset_o && m < 20) begin
            step();
            m++;
        end
        chk("rst_pulse_len", m, 4);
        chk("tmo_idle", {31'd0, busy_o}, 32'd0);
        chk("tmo_no_wr0", tot[0] - base_tot[0], 0);
        chk("tmo_no_wr1", tot[1] - base_tot[1], 0);
        chk("tmo_err_kept", {24'd0, err_count_o}, 32'd3);

        // Next recovery sees a cleared shadow file
        snap();
        halted = 2'b11;
        pc = 32'h200;
        step();
        drive_mismatch();
        pc = 32'h204;
        step();
        idle_in();
        wait_idle(100, n);
        chk("clr_done", {31'd0, busy_o}, 32'd0);
        chk("clr_gpr5", wdat[0][5], 32'd0);
        chk("clr_npc", wdat[0][32], 32'h200);
        chk("err_4", {24'd0, err_count_o}, 32'd4);

        // Error counter saturation
        tmo = 0;
        for (int i = 0; i < 251; i++) begin
            drive_mismatch();
            step();
            idle_in();
            wait_idle(60, n);
            if (busy_o) tmo++;
        end
        chk("sat_255", {24'd0, err_count_o}, 32'd255);
        for (int i = 0; i < 10; i++) begin
            drive_mismatch();
            step();
            idle_in();
            wait_idle(60, n);
            if (busy_o) tmo++;
        end
        chk("sat_hold", {24'd0, err_count_o}, 32'd255);
        chk("sat_timeouts", tmo, 0);

        // Reset in the middle of a GPR handshake
        drive_mismatch();
        auto_gnt = 1'b0;
        man_gnt = 2'b00;
        step();
        idle_in();
        step();
        step();
        step();
        chk("mid_req", {30'd0, dif.req}, 32'd3);
        chk("mid_we", {31'd0, dif.we}, 32'd1);
        rst_ni = 1'b0;
        step();
        chk_reset_outputs("mid_rst");
        rst_ni = 1'b1;
        auto_gnt = 1'b1;
        step();
        chk("post_rst_busy", {31'd0, busy_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
